video_route_sequencer: RTL and testbench

//  Sequences route changes for the video effect-chain mux. Captures requested per-stage source selects
//  and validates them: legal codes, and the output chain must terminate at base within 6 hops.

---
 rtl/video_route_pkg.sv | 59 +++++
 rtl/video_route_walker.sv | 54 +++++
 rtl/video_route_sequencer.sv | 145 ++++++++++++++
 tb/tb_video_route_sequencer.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/video_route_pkg.sv
// Shared types and helpers for the video route sequencer: source codes, FSM states, route bundle
// and the resolve/stage lookups used to walk the output chain.
package video_route_pkg;

   typedef enum logic [2:0] {
      SRC_BASE       = 3'b000,
      SRC_DELAY      = 3'b001,
      SRC_REVERB     = 3'b010,
      SRC_FILTER     = 3'b011,
      SRC_DISTORTION = 3'b100,
      SRC_CRUSH      = 3'b101
   } route_src_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CHECK,
      ST_WALK,
      ST_WAIT_FRAME,
      ST_BLANK
   } state_e;

   typedef struct packed {
      logic [2:0] output_src;
      logic [2:0] delay_src;
      logic [2:0] reverb_src;
      logic [2:0] filter_src;
      logic [2:0] distortion_src;
      logic [2:0] crush_src;
   } route_t;

   function automatic logic [2:0] resolve(input logic [2:0] sel, input logic [2:0] delay_src);
      return (sel == SRC_DELAY) ? delay_src : sel;
   endfunction

   function automatic logic [2:0] stage_sel(input logic [2:0] node, input route_t snap);
      logic [2:0] sel;
      sel = SRC_BASE;
      case (node)
         SRC_DELAY:      sel = snap.delay_src;
         SRC_REVERB:     sel = snap.reverb_src;
         SRC_FILTER:     sel = snap.filter_src;
         SRC_DISTORTION: sel = snap.distortion_src;
         SRC_CRUSH:      sel = snap.crush_src;
         default:        sel = SRC_BASE;
      endcase
      return sel;
   endfunction

   function automatic logic code_illegal(input logic [2:0] c);
      return c[2] & c[1];
   endfunction

   function automatic logic route_illegal(input route_t r);
      return code_illegal(r.output_src) | code_illegal(r.delay_src) | code_illegal(r.reverb_src) |
             code_illegal(r.filter_src) | code_illegal(r.distortion_src) |
             code_illegal(r.crush_src) | (r.delay_src == SRC_DELAY);
   endfunction

endpackage

// File: rtl/video_route_walker.sv
// Route validator datapath: checks codes on start, then follows the output chain one hop per cycle.
// accept/reject are combinational from the current node; the parent decides whether to honour them.
module video_route_walker
   import video_route_pkg::*;
#(
   parameter int MAX_HOPS = 6
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   start,
   input  logic   step,
   input  logic   abort,
   input  route_t snap,
   output logic   accept,
   output logic   reject
);

   localparam int HOP_W = (MAX_HOPS > 1) ? $clog2(MAX_HOPS) : 1;

   logic [2:0]       node_q, node_d;
   logic [HOP_W-1:0] hops_q, hops_d;

   always_comb begin
      node_d = node_q;
      hops_d = hops_q;
      accept = 1'b0;
      reject = 1'b0;
      if (start) begin
         reject = route_illegal(snap);
         if (!abort && !reject) begin
            node_d = resolve(snap.output_src, snap.delay_src);
            hops_d = '0;
         end
      end else if (step) begin
         accept = (node_q == SRC_BASE);
         reject = !accept && (hops_q == HOP_W'(MAX_HOPS - 1));
         if (!abort && !accept && !reject) begin
            node_d = resolve(stage_sel(node_q, snap), snap.delay_src);
            hops_d = hops_q + HOP_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         node_q <= SRC_BASE;
         hops_q <= '0;
      end else begin
         node_q <= node_d;
         hops_q <= hops_d;
      end
   end

endmodule

// File: rtl/video_route_sequencer.sv
// Validates requested effect-chain routes and commits good ones on a frame boundary, then blanks video.
// A change of the live request while checking or waiting abandons the attempt; no backpressure.
module video_route_sequencer
   import video_route_pkg::*;
#(
   parameter int BLANK_FRAMES = 2,
   parameter int MAX_HOPS     = 6
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       frame_start,
   input  logic [2:0] req_output_src,
   input  logic [2:0] req_delay_src,
   input  logic [2:0] req_reverb_src,
   input  logic [2:0] req_filter_src,
   input  logic [2:0] req_distortion_src,
   input  logic [2:0] req_crush_src,
   output logic [2:0] output_src,
   output logic [2:0] delay_src,
   output logic [2:0] reverb_src,
   output logic [2:0] filter_src,
   output logic [2:0] distortion_src,
   output logic [2:0] crush_src,
   output logic       video_blank,
   output logic       busy,
   output logic       route_error
);

   localparam int CNT_W = (BLANK_FRAMES > 0) ? $clog2(BLANK_FRAMES + 1) : 1;

   state_e           state_q, state_d;
   route_t           snap_q, snap_d;
   route_t           rej_q, rej_d;
   route_t           com_q, com_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             blank_q, blank_d;
   logic             busy_q, busy_d;
   logic             err_q, err_d;

   route_t req;
   logic   req_chg;
   logic   walk_accept, walk_reject;

   assign req = '{output_src: req_output_src, delay_src: req_delay_src,
                  reverb_src: req_reverb_src, filter_src: req_filter_src,
                  distortion_src: req_distortion_src, crush_src: req_crush_src};
   assign req_chg = (req != snap_q);

   video_route_walker #(.MAX_HOPS(MAX_HOPS)) u_walker (
      .clk    (clk),
      .rst    (rst),
      .start  (state_q == ST_CHECK),
      .step   (state_q == ST_WALK),
      .abort  (req_chg),
      .snap   (snap_q),
      .accept (walk_accept),
      .reject (walk_reject)
   );

   always_comb begin
      state_d = state_q;
      snap_d  = snap_q;
      rej_d   = rej_q;
      com_d   = com_q;
      cnt_d   = cnt_q;
      blank_d = blank_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: begin
            if (req != com_q && req != rej_q) begin
               snap_d  = req;
               state_d = ST_CHECK;
            end
         end
         ST_CHECK, ST_WALK: begin
            if (req_chg) begin
               state_d = ST_IDLE;
            end else if (walk_reject) begin
               rej_d   = snap_q;
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else if (walk_accept) begin
               err_d   = 1'b0;
               state_d = ST_WAIT_FRAME;
            end else begin
               state_d = ST_WALK;
            end
         end
         ST_WAIT_FRAME: begin
            if (req_chg) begin
               state_d = ST_IDLE;
            end else if (frame_start) begin
               com_d   = snap_q;
               blank_d = (BLANK_FRAMES != 0);
               cnt_d   = CNT_W'(BLANK_FRAMES);
               state_d = (BLANK_FRAMES != 0) ? ST_BLANK : ST_IDLE;
            end
         end
         ST_BLANK: begin
            if (frame_start) begin
               cnt_d = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  blank_d = 1'b0;
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         snap_q  <= '0;
         rej_q   <= '0;
         com_q   <= '0;
         cnt_q   <= '0;
         blank_q <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         snap_q  <= snap_d;
         rej_q   <= rej_d;
         com_q   <= com_d;
         cnt_q   <= cnt_d;
         blank_q <= blank_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
      end
   end

   assign output_src     = com_q.output_src;
   assign delay_src      = com_q.delay_src;
   assign reverb_src     = com_q.reverb_src;
   assign filter_src     = com_q.filter_src;
   assign distortion_src = com_q.distortion_src;
   assign crush_src      = com_q.crush_src;
   assign video_blank    = blank_q;
   assign busy           = busy_q;
   assign route_error    = err_q;

endmodule

// File: tb/tb_video_route_sequencer.sv
// Scoreboarded bench: expected committed routes are queued as requests are driven and checked
// whenever the committed selects change.
module tb_video_route_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       frame_start = 1'b0;
   logic [2:0] req_output_src = '0, req_delay_src = '0, req_reverb_src = '0;
   logic [2:0] req_filter_src = '0, req_distortion_src = '0, req_crush_src = '0;
   logic [2:0] output_src, delay_src, reverb_src, filter_src, distortion_src, crush_src;
   logic       video_blank, busy, route_error;

   int n_cmp = 0;
   int n_mis = 0;
   logic [17:0] sb_q[$];
   logic [17:0] prev_bus;
   logic [17:0] exp_bus;
   logic        mon_fs, mon_rs;
   int          busy_cnt;

   video_route_sequencer #(.BLANK_FRAMES(2), .MAX_HOPS(6)) dut (
      .clk                (clk),
      .rst                (rst),
      .frame_start        (frame_start),
      .req_output_src     (req_output_src),
      .req_delay_src      (req_delay_src),
      .req_reverb_src     (req_reverb_src),
      .req_filter_src     (req_filter_src),
      .req_distortion_src (req_distortion_src),
      .req_crush_src      (req_crush_src),
      .output_src         (output_src),
      .delay_src          (delay_src),
      .reverb_src         (reverb_src),
      .filter_src         (filter_src),
      .distortion_src     (distortion_src),
      .crush_src          (crush_src),
      .video_blank        (video_blank),
      .busy               (busy),
      .route_error        (route_error)
   );

   always #5 clk = ~clk;

   function automatic logic [17:0] sel_bus();
      return {output_src, delay_src, reverb_src, filter_src, distortion_src, crush_src};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic frame();
      frame_start = 1'b1;
      tick(1);
      frame_start = 1'b0;
   endtask

   task automatic set_req(input logic [17:0] r);
      {req_output_src, req_delay_src, req_reverb_src,
       req_filter_src, req_distortion_src, req_crush_src} = r;
   endtask

   // Every non-reset change of the committed selects must follow a frame_start and match the queue head.
   always @(posedge clk) begin
      mon_fs = frame_start;
      mon_rs = rst;
      #1;
      if (!mon_rs && sel_bus() != prev_bus) begin
         check("commit_on_frame", 32'(mon_fs), 32'd1);
         if (sb_q.size() == 0) begin
            check("unexpected_commit", 32'(sel_bus()), 32'(prev_bus));
         end else begin
            exp_bus = sb_q.pop_front();
            check("commit_route", 32'(sel_bus()), 32'(exp_bus));
         end
      end
      prev_bus = sel_bus();
   end

   initial begin
      prev_bus = '0;
      tick(3);
      rst = 1'b0;
      tick(10);
      check("rst_selects", 32'(sel_bus()), 32'd0);
      check("rst_blank", 32'(video_blank), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_error", 32'(route_error), 32'd0);

      // output -> reverb -> base
      set_req({3'b010, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000});
      sb_q.push_back({3'b010, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000});
      tick(15);
      check("wait_busy", 32'(busy), 32'd1);
      check("wait_no_commit", 32'(output_src), 32'd0);
      frame();
      check("commit_output", 32'(output_src), 32'b010);
      check("blank_f0", 32'(video_blank), 32'd1);
      tick(20);
      frame();
      check("blank_f1", 32'(video_blank), 32'd1);
      tick(20);
      frame();
      check("blank_end", 32'(video_blank), 32'd0);
      check("busy_end", 32'(busy), 32'd0);

      // filter <-> reverb loop on the output chain
      set_req({3'b011, 3'b000, 3'b011, 3'b010, 3'b000, 3'b000});
      for (int i = 0; i < 9 && !route_error; i++) tick(1);
      check("loop_error", 32'(route_error), 32'd1);
      check("loop_selects", 32'(sel_bus()), 32'({3'b010, 15'd0}));
      check("loop_no_blank", 32'(video_blank), 32'd0);
      busy_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         if (busy) busy_cnt++;
         if (i == 10) frame_start = 1'b1;
         if (i == 11) frame_start = 1'b0;
      end
      check("loop_no_retrigger", 32'(busy_cnt), 32'd0);
      check("loop_error_hold", 32'(route_error), 32'd1);

      // output -> delay(distortion) -> base
      set_req({3'b001, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000});
      sb_q.push_back({3'b001, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000});
      tick(12);
      check("delay_accept_clears", 32'(route_error), 32'd0);
      frame();
      check("delay_commit", 32'(output_src), 32'b001);
      tick(5); frame(); tick(5); frame();
      check("delay_busy_end", 32'(busy), 32'd0);
      set_req({3'b001, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000});
      tick(5);
      check("delay_self_error", 32'(route_error), 32'd1);
      check("delay_self_selects", 32'(sel_bus()), 32'({3'b001, 3'b100, 12'd0}));

      // pending route replaced before the frame boundary
      set_req({3'b101, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000});
      tick(12);
      check("abort_pending_busy", 32'(busy), 32'd1);
      req_crush_src = 3'b010;
      sb_q.push_back({3'b101, 3'b100, 3'b000, 3'b000, 3'b000, 3'b010});
      tick(12);
      frame();
      check("abort_new_commit", 32'(sel_bus()), 32'({3'b101, 3'b100, 3'b000, 3'b000, 3'b000, 3'b010}));
      tick(5); frame(); tick(5); frame();
      check("abort_busy_end", 32'(busy), 32'd0);

      // reset during blanking
      set_req({3'b011, 3'b100, 3'b000, 3'b000, 3'b000, 3'b010});
      sb_q.push_back({3'b011, 3'b100, 3'b000, 3'b000, 3'b000, 3'b010});
      tick(10);
      frame();
      check("rstblank_commit", 32'(output_src), 32'b011);
      check("rstblank_blank", 32'(video_blank), 32'd1);
      tick(3);
      rst = 1'b1;
      tick(1);
      check("midrst_blank", 32'(video_blank), 32'd0);
      check("midrst_selects", 32'(sel_bus()), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      set_req('0);
      tick(2);
      rst = 1'b0;
      tick(3);
      check("sb_drained", 32'(sb_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
